serial_deframer: RTL

//   Receive-side stage fed by the serial output (dout_n) of a shift_reg chain or any 1-bit line.
//   Bit-synchronous: one line bit is sampled per en strobe. The stage detects a start bit,

---
 rtl/serial_deframer_pkg.sv | 23 ++
 rtl/serial_deframer_if.sv | 30 +++
 rtl/serial_deframer_shift.sv | 34 +++
 rtl/serial_deframer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/serial_deframer_pkg.sv
// Shared types and helpers for the serial deframer.
// Contents:
//   dfr_state_e - FSM state encoding (3 bits)
//   MaxN        - widest supported data word
//   parity_of   - XOR reduction of a zero-extended word
package serial_deframer_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StData     = 3'd1,
    StParity   = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } dfr_state_e;

  localparam int unsigned MaxN = 32;

  // Zero extension does not change the XOR, so any word up to MaxN bits can be passed in.
  function automatic logic parity_of(input logic [MaxN-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_deframer_if.sv
// Bundle of line-side inputs and word-side outputs of the serial deframer.
// Signals:
//   en, din                   - bit strobe and serial line (line side drives)
//   dout, dout_valid          - received word and its one-cycle valid pulse
//   err_parity, err_frame     - one-cycle error pulses
//   busy                      - deframer is inside a frame
// Modports: master = line/driver side, slave = the deframer.
interface serial_deframer_if #(
  parameter int unsigned N = 8
);

  logic         en;
  logic         din;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         err_parity;
  logic         err_frame;
  logic         busy;

  modport master (
    output en, din,
    input  dout, dout_valid, err_parity, err_frame, busy
  );

  modport slave (
    input  en, din,
    output dout, dout_valid, err_parity, err_frame, busy
  );

endinterface

// File: rtl/serial_deframer_shift.sv
// Right-shifting capture register: each enabled cycle shifts din into the MSB, so after N
// shifts the first bit received sits at the LSB. A parallel load has priority over shifting.
// Ports:
//   clk, res_n  - clock and synchronous active-low reset (clears the register)
//   en, din     - shift enable and serial input
//   load_en     - parallel load strobe, load_data is the value loaded
//   dout        - register contents
module serial_deframer_shift #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         din,
  input  logic         load_en,
  input  logic [N-1:0] load_data,
  output logic [N-1:0] dout
);

  logic [N-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      shift_q <= '0;
    end else if (load_en) begin
      shift_q <= load_data;
    end else if (en) begin
      shift_q <= {din, shift_q[N-1:1]};
    end
  end

  assign dout = shift_q;

endmodule

// File: rtl/serial_deframer.sv
// Bit-synchronous serial deframer. One line bit is sampled per en strobe: a 0 in IDLE is a
// start bit, then N data bits LSB-first, an optional parity bit and STOP_BITS stop bits.
// A completed frame yields a one-cycle dout_valid (good frame), err_parity and/or err_frame.
// A bad stop bit parks the FSM in WAIT_IDLE until the line returns to 1, so a break is never
// mistaken for a start bit.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   res_n  - synchronous active-low reset, aborts any frame without pulses
//   bus    - serial_deframer_if slave: en/din in; dout, dout_valid, err_parity, err_frame,
//            busy out (all outputs registered)
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic              clk,
  input logic              res_n,
  serial_deframer_if.slave bus
);

  localparam int unsigned CntW = $clog2(N + 1);

  dfr_state_e    state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic          stop_cnt_q;
  logic          par_bad_q;
  logic [N-1:0]  dout_q;
  logic          dout_valid_q;
  logic          err_parity_q;
  logic          err_frame_q;
  logic          busy_q;

  logic [N-1:0]  word;
  logic          shift_en;
  logic          par_mismatch;

  assign shift_en = bus.en && (state_q == StData);

  serial_deframer_shift #(
    .N(N)
  ) u_shift (
    .clk      (clk),
    .res_n    (res_n),
    .en       (shift_en),
    .din      (bus.din),
    .load_en  (1'b0),
    .load_data('0),
    .dout     (word)
  );

  // word already holds all N data bits by the time the parity bit is sampled.
  assign par_mismatch = parity_of(MaxN'(word)) ^ bus.din ^ PARITY_ODD[0];

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Pulses always clear on the following clock, independent of en.
      dout_valid_q <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          StIdle: begin
            if (!bus.din) begin
              state_q    <= StData;
              bit_cnt_q  <= '0;
              stop_cnt_q <= 1'b0;
              par_bad_q  <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
          StData: begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CntW'(N - 1)) begin
              state_q <= (PARITY_EN != 0) ? StParity : StStop;
            end
          end
          StParity: begin
            par_bad_q <= par_mismatch;
            state_q   <= StStop;
          end
          StStop: begin
            if (!bus.din) begin
              state_q      <= StWaitIdle;
              err_frame_q  <= 1'b1;
              err_parity_q <= par_bad_q;
            end else if (32'(stop_cnt_q) == STOP_BITS - 1) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              if (par_bad_q) begin
                err_parity_q <= 1'b1;
              end else begin
                dout_q       <= word;
                dout_valid_q <= 1'b1;
              end
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
          StWaitIdle: begin
            if (bus.din) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.err_parity = err_parity_q;
  assign bus.err_frame  = err_frame_q;
  assign bus.busy       = busy_q;

endmodule
